// File: rtl/sin_pkg.sv
// Shared types and constants for the sin_responder bus slave.
package sin_pkg;

  localparam logic [31:0] SIN_BASE_ADDR = 32'hA000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } sin_state_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rd_data;
  } sin_resp_t;

  // Window hit: upper 24 address bits match the base and the access is word aligned.
  function automatic logic sin_addr_hit(logic [23:0] addr_hi, logic [1:0] addr_lo,
                                        logic [23:0] base_hi);
    return (addr_hi == base_hi) && (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/sin_responder_if.sv
// Single-request bus between the sample master and the sin_responder slave.
interface sin_responder_if;

  logic        exec;
  logic        we;
  logic [31:0] si_address;
  logic [31:0] si_data;
  logic        fin;
  logic [31:0] rd_data;
  logic        err;

  modport master (
    output exec, we, si_address, si_data,
    input  fin, rd_data, err
  );

  modport slave (
    input  exec, we, si_address, si_data,
    output fin, rd_data, err
  );

endinterface

// File: rtl/sin_wordmem.sv
// Single-port word buffer: synchronous write, registered read, array not reset.
module sin_wordmem #(
  parameter int unsigned Depth = 64,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // Write on we_i; read data only moves on re_i so it stays stable between reads.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sin_responder.sv
// Slave responder: accepts one request at a time, decodes a word window, stores
// writes into a local buffer, returns read data with a fixed-latency fin pulse and
// tracks how many words have been captured toward a full frame.
module sin_responder
  import sin_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = SIN_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned FIN_LATENCY = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  sin_responder_if.slave                     bus,
  input  logic                               clr,
  output logic [$clog2(DEPTH_WORDS+1)-1:0]   words_written,
  output logic                               frame_full,
  output logic                               frame_done
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = $clog2(DEPTH_WORDS + 1);
  localparam logic [CntW-1:0] CntFull    = CntW'(DEPTH_WORDS);
  localparam logic [CntW-1:0] CntFullM1  = CntW'(DEPTH_WORDS - 1);
  localparam logic [3:0]      LatInit    = 4'(FIN_LATENCY - 1);

  sin_state_t      state_q, state_d;
  logic [3:0]      lat_q, lat_d;
  logic [CntW-1:0] count_q, count_d;
  logic            frame_full_q, frame_full_d;
  logic            frame_done_q, frame_done_d;
  logic            fin_q;
  logic            err_q;
  logic            rd_valid_q;

  logic            accept;
  logic            hit;
  logic            wr_hit;
  logic            rd_hit;
  logic [31:0]     mem_rdata;
  sin_resp_t       resp;

  assign accept = (state_q == IDLE) && bus.exec;
  assign hit    = sin_addr_hit(bus.si_address[31:8], bus.si_address[1:0], BASE_ADDR[31:8]);
  assign wr_hit = accept && bus.we && hit;
  assign rd_hit = accept && !bus.we && hit;

  sin_wordmem #(
    .Depth (DEPTH_WORDS),
    .AddrW (IdxW)
  ) u_wordmem (
    .clk_i   (clk),
    .we_i    (wr_hit),
    .re_i    (rd_hit),
    .addr_i  (bus.si_address[IdxW+1:2]),
    .wdata_i (bus.si_data),
    .rdata_o (mem_rdata)
  );

  // Request FSM: the latency counter ends WAIT on the cycle its next value would be zero.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          lat_d   = LatInit;
          state_d = (FIN_LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame counter: clr overrides a coincident write hit, so no frame_done then.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (wr_hit && (count_q != CntFull)) begin
      count_d = count_q + 1'b1;
    end
    frame_full_d = (count_d == CntFull);
    frame_done_d = !clr && wr_hit && (count_q == CntFullM1);
  end

  // State, counters and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      count_q      <= '0;
      frame_full_q <= 1'b0;
      frame_done_q <= 1'b0;
      fin_q        <= 1'b0;
      err_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      count_q      <= count_d;
      frame_full_q <= frame_full_d;
      frame_done_q <= frame_done_d;
      // fin follows DONE by one edge so it lands FIN_LATENCY edges after acceptance.
      fin_q        <= (state_q == DONE);
      if (accept) begin
        err_q      <= !hit;
        rd_valid_q <= rd_hit;
      end
    end
  end

  // Read data is only exposed for a read hit; misses and writes return zero.
  always_comb begin
    resp.err     = err_q;
    resp.rd_data = rd_valid_q ? mem_rdata : 32'h0;
  end

  assign bus.fin       = fin_q;
  assign bus.err       = resp.err;
  assign bus.rd_data   = resp.rd_data;
  assign words_written = count_q;
  assign frame_full    = frame_full_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_sin_responder.sv
// Scoreboard bench for sin_responder: one instance at FIN_LATENCY=1, one at 4.
module tb_sin_responder;
  import sin_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       clr1, clr4;
  logic [6:0] ww1, ww4;
  logic       ff1, ff4, fd1, fd4;

  sin_responder_if bus1();
  sin_responder_if bus4();

  sin_responder #(
    .BASE_ADDR   (32'hA000_0000),
    .DEPTH_WORDS (64),
    .FIN_LATENCY (1)
  ) u_dut1 (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus1.slave),
    .clr           (clr1),
    .words_written (ww1),
    .frame_full    (ff1),
    .frame_done    (fd1)
  );

  sin_responder #(
    .BASE_ADDR   (32'hA000_0000),
    .DEPTH_WORDS (64),
    .FIN_LATENCY (4)
  ) u_dut4 (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus4.slave),
    .clr           (clr4),
    .words_written (ww4),
    .frame_full    (ff4),
    .frame_done    (fd4)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
    bit          chk_data;
    int          fin_cyc;
    string       tag;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int fd1_cnt = 0;
  int fd_base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard for the latency-1 instance: every fin pops one expectation.
  always @(negedge clk) begin
    if (fd1 === 1'b1) fd1_cnt++;
    if (bus1.fin === 1'b1) begin
      if (q1.size() == 0) begin
        check_val("fin1_unexpected", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        check_val({e1.tag, "_fin_cycle"}, cyc, e1.fin_cyc);
        check_val({e1.tag, "_err"}, {31'd0, bus1.err}, {31'd0, e1.err});
        if (e1.chk_data) check_val({e1.tag, "_rd_data"}, bus1.rd_data, e1.data);
      end
    end
  end

  // Scoreboard for the latency-4 instance.
  always @(negedge clk) begin
    if (bus4.fin === 1'b1) begin
      if (q4.size() == 0) begin
        check_val("fin4_unexpected", 32'd1, 32'd0);
      end else begin
        e4 = q4.pop_front();
        check_val({e4.tag, "_fin_cycle"}, cyc, e4.fin_cyc);
        check_val({e4.tag, "_err"}, {31'd0, bus4.err}, {31'd0, e4.err});
        if (e4.chk_data) check_val({e4.tag, "_rd_data"}, bus4.rd_data, e4.data);
      end
    end
  end

  task automatic wait_empty1(input string tag);
    for (int i = 0; i < 40 && q1.size() != 0; i++) @(negedge clk);
    if (q1.size() != 0) begin
      check_val({tag, "_timeout"}, q1.size(), 32'd0);
      q1.delete();
    end
  endtask

  task automatic wait_empty4(input string tag);
    for (int i = 0; i < 80 && q4.size() != 0; i++) @(negedge clk);
    if (q4.size() != 0) begin
      check_val({tag, "_timeout"}, q4.size(), 32'd0);
      q4.delete();
    end
  endtask

  task automatic req1(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic exp_err,
                      input logic [31:0] exp_data, input bit chk_data, input logic clr_v);
    exp_t e;
    @(negedge clk);
    bus1.exec = 1'b1; bus1.we = we; bus1.si_address = addr; bus1.si_data = data;
    clr1 = clr_v;
    @(posedge clk);
    #1;
    e.err = exp_err; e.data = exp_data; e.chk_data = chk_data; e.fin_cyc = cyc + 1; e.tag = tag;
    q1.push_back(e);
    bus1.exec = 1'b0;
    clr1 = 1'b0;
    wait_empty1(tag);
  endtask

  task automatic req4(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic exp_err,
                      input logic [31:0] exp_data, input bit chk_data);
    exp_t e;
    @(negedge clk);
    bus4.exec = 1'b1; bus4.we = we; bus4.si_address = addr; bus4.si_data = data;
    @(posedge clk);
    #1;
    e.err = exp_err; e.data = exp_data; e.chk_data = chk_data; e.fin_cyc = cyc + 4; e.tag = tag;
    q4.push_back(e);
    bus4.exec = 1'b0;
    wait_empty4(tag);
  endtask

  task automatic pulse_clr1();
    @(negedge clk);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    check_val("clr_count", {25'd0, ww1}, 32'd0);
    check_val("clr_full", {31'd0, ff1}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   e0;

    reset = 1'b1;
    clr1 = 1'b0; clr4 = 1'b0;
    bus1.exec = 1'b0; bus1.we = 1'b0; bus1.si_address = '0; bus1.si_data = '0;
    bus4.exec = 1'b0; bus4.we = 1'b0; bus4.si_address = '0; bus4.si_data = '0;
    repeat (3) @(negedge clk);
    check_val("rst_fin", {31'd0, bus1.fin}, 32'd0);
    check_val("rst_err", {31'd0, bus1.err}, 32'd0);
    check_val("rst_rd_data", bus1.rd_data, 32'd0);
    check_val("rst_count", {25'd0, ww1}, 32'd0);
    check_val("rst_full", {31'd0, ff1}, 32'd0);
    check_val("rst_done", {31'd0, fd1}, 32'd0);
    check_val("rst_fin4", {31'd0, bus4.fin}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic write/read at latency 1.
    req1("wr_beef", 1'b1, 32'hA000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0);
    check_val("wr_beef_count", {25'd0, ww1}, 32'd1);
    req1("rd_beef", 1'b0, 32'hA000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    req1("wr_idx0", 1'b1, 32'hA000_0000, 32'h1111_0000, 1'b0, 32'h0, 1'b0, 1'b0);
    check_val("wr_idx0_count", {25'd0, ww1}, 32'd2);

    // Misses: out-of-window write and misaligned read.
    req1("wr_miss", 1'b1, 32'hB000_0000, 32'h0000_0BAD, 1'b1, 32'h0, 1'b1, 1'b0);
    req1("rd_misalign", 1'b0, 32'hA000_0002, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    check_val("miss_count", {25'd0, ww1}, 32'd2);
    req1("rd_idx0", 1'b0, 32'hA000_0000, 32'h0, 1'b0, 32'h1111_0000, 1'b1, 1'b0);

    // Latency 4: one write, then exec held high for back-to-back reads.
    req4("wr4", 1'b1, 32'hA000_0004, 32'h0404_0404, 1'b0, 32'h0, 1'b0);
    check_val("wr4_count", {25'd0, ww4}, 32'd1);
    @(negedge clk);
    e0 = cyc + 1;
    bus4.exec = 1'b1; bus4.we = 1'b0; bus4.si_address = 32'hA000_0004;
    for (int k = 0; k < 4; k++) begin
      e.err = 1'b0; e.data = 32'h0404_0404; e.chk_data = 1'b1;
      e.fin_cyc = e0 + 5 * k + 4; e.tag = "b2b";
      q4.push_back(e);
    end
    repeat (20) @(posedge clk);
    #1;
    bus4.exec = 1'b0;
    wait_empty4("b2b");
    repeat (6) @(negedge clk);

    // Fill a full frame, then overflow by one.
    pulse_clr1();
    fd_base = fd1_cnt;
    for (int i = 0; i < 64; i++) begin
      req1("fill", 1'b1, 32'hA000_0000 + 32'(i * 4), 32'h5A00_0000 + 32'(i),
           1'b0, 32'h0, 1'b0, 1'b0);
      if (i == 62) begin
        check_val("fill63_count", {25'd0, ww1}, 32'd63);
        check_val("fill63_full", {31'd0, ff1}, 32'd0);
      end
    end
    check_val("fill64_count", {25'd0, ww1}, 32'd64);
    check_val("fill64_full", {31'd0, ff1}, 32'd1);
    check_val("fill64_done_pulses", fd1_cnt - fd_base, 32'd1);
    req1("fill65", 1'b1, 32'hA000_0000, 32'h6565_6565, 1'b0, 32'h0, 1'b0, 1'b0);
    check_val("fill65_count", {25'd0, ww1}, 32'd64);
    check_val("fill65_full", {31'd0, ff1}, 32'd1);
    check_val("fill65_done_pulses", fd1_cnt - fd_base, 32'd1);
    req1("rd_0", 1'b0, 32'hA000_0000, 32'h0, 1'b0, 32'h6565_6565, 1'b1, 1'b0);
    req1("rd_80", 1'b0, 32'hA000_0080, 32'h0, 1'b0, 32'h5A00_0020, 1'b1, 1'b0);

    // clr coinciding with the 64th write.
    pulse_clr1();
    fd_base = fd1_cnt;
    for (int i = 0; i < 63; i++) begin
      req1("refill", 1'b1, 32'hA000_0000 + 32'(i * 4), 32'h3C00_0000 + 32'(i),
           1'b0, 32'h0, 1'b0, 1'b0);
    end
    check_val("refill63_count", {25'd0, ww1}, 32'd63);
    req1("wr64_clr", 1'b1, 32'hA000_00FC, 32'hC1C1_C1C1, 1'b0, 32'h0, 1'b0, 1'b1);
    check_val("clr64_count", {25'd0, ww1}, 32'd0);
    check_val("clr64_full", {31'd0, ff1}, 32'd0);
    check_val("clr64_done_pulses", fd1_cnt - fd_base, 32'd0);
    req1("rd_fc", 1'b0, 32'hA000_00FC, 32'h0, 1'b0, 32'hC1C1_C1C1, 1'b1, 1'b0);

    // Reset while the latency-4 instance is in WAIT after a write acceptance.
    @(negedge clk);
    bus4.exec = 1'b1; bus4.we = 1'b1; bus4.si_address = 32'hA000_0020;
    bus4.si_data = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    bus4.exec = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_val("midrst_fin", {31'd0, bus4.fin}, 32'd0);
    check_val("midrst_err", {31'd0, bus4.err}, 32'd0);
    check_val("midrst_rd_data", bus4.rd_data, 32'd0);
    check_val("midrst_count", {25'd0, ww4}, 32'd0);
    check_val("midrst_full", {31'd0, ff4}, 32'd0);
    check_val("midrst_done", {31'd0, fd4}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check_val("postrst_count", {25'd0, ww4}, 32'd0);
    req4("rd_after_rst", 1'b0, 32'hA000_0020, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b1);
    req1("rd1_after_rst", 1'b0, 32'hA000_00FC, 32'h0, 1'b0, 32'hC1C1_C1C1, 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sin_responder.md
# sin_responder

Slave-side responder for the `mdriver_int` single-request bus driven by the sample master. Accepts `exec` requests, decodes a 256-byte window at `BASE_ADDR`, and stores written words into a local 64×32 buffer. Returns read data, signals completion with a one-cycle `fin` pulse after a fixed latency, and counts captured words so downstream logic knows when a full frame is available.

## Interface
Parameters:
- `BASE_ADDR`, 32'hA000_0000: window base; only `si_address[31:8]` is compared against it.
- `DEPTH_WORDS`, 64: buffer depth in 32-bit words (window = 4×DEPTH_WORDS bytes).
- `FIN_LATENCY`, 1: cycles from acceptance edge to `fin`; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; all state cleared on assertion.
- `exec`  in  1  request strobe from master; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; qualified by `exec`.
- `si_address`  in  32  byte address.
- `si_data`  in  32  write data.
- `fin`  out  1  one-cycle completion pulse.
- `rd_data`  out  32  read data; valid when `fin` = 1.
- `err`  out  1  request error; valid when `fin` = 1.
- `clr`  in  1  clears word count and `frame_full`.
- `words_written`  out  7  saturating count of successful writes since reset/clr.
- `frame_full`  out  1  level, high while `words_written` == DEPTH_WORDS.
- `frame_done`  out  1  one-cycle pulse on the transition to full.

## Operation
- FSM states: IDLE, WAIT, DONE.
  - IDLE: `exec` = 1 at a rising edge → accept; latch `we`, address, data; load latency counter with FIN_LATENCY-1.
  - Next state is WAIT, or DONE if FIN_LATENCY = 1.
  - WAIT: decrement counter; go to DONE when it reaches 0.
  - DONE: `fin` = 1 for exactly this cycle; next state IDLE.
- `exec` in WAIT/DONE is ignored. `exec` still high in IDLE after DONE is a new request.
- Decode: hit = (`si_address[31:8]` == `BASE_ADDR[31:8]`) and `si_address[1:0]` == 0; word index = `si_address[7:2]`.
- `err` = !hit. A miss performs no write and returns `rd_data` = 32'h0.
- Write hit: memory written at the acceptance edge; counter increments at the same edge.
- Read hit: `rd_data` registered at the acceptance edge; a same-cycle write cannot occur (single outstanding request). Held stable through DONE.
- `words_written`: +1 per write hit, saturating at DEPTH_WORDS. Rewriting the same index still counts.
- `frame_done` pulses the cycle after the count goes DEPTH_WORDS-1 → DEPTH_WORDS.
- `clr`: count ← 0 and `frame_full` ← 0 next edge. If `clr` and a write hit coincide, `clr` wins (count 0, no `frame_done`), but the data is still stored. `clr` does not affect the FSM.

## Timing
- Reset values: state IDLE; `fin` 0; `err` 0; `rd_data` 0; `words_written` 0; `frame_full` 0; `frame_done` 0. Buffer contents are not reset.
- Latency: with acceptance at edge N, `fin` is high between edges N+FIN_LATENCY and N+FIN_LATENCY+1.
- Throughput: one request per FIN_LATENCY+1 cycles maximum.
- Reset mid-request: request is dropped, no `fin` is issued, and any write already performed at acceptance remains in the buffer.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `sin_pkg`:
  - `SIN_BASE_ADDR` constant.
  - `sin_state_t` enum {IDLE, WAIT, DONE}.
  - `sin_resp_t` struct {`err`, `rd_data`}.
- Sub-module `sin_wordmem`: DEPTH_WORDS×32 storage with synchronous write and registered read, single port, no reset on the array.
- Top module holds the FSM, decode, latency counter and frame counter.

## Test plan
- Reset, then write 32'hDEAD_BEEF to A000_0010 with FIN_LATENCY=1 → `fin` one cycle after acceptance, `err`=0, `words_written`=1. A subsequent read of A000_0010 returns DEAD_BEEF.
- FIN_LATENCY=4, back-to-back `exec` held high → `fin` every 5 cycles; `exec` during WAIT is not accepted.
- Write to B000_0000 and read of A000_0002 → each gives `err`=1, `rd_data`=0, no count change, buffer unchanged.
- 64 consecutive writes A000_0000..A000_00FC → `frame_done` pulses once after the 64th. `frame_full`=1, count stays 64 after a 65th write.
- `clr` asserted in the same cycle as the 64th write → count 0, no `frame_done`, and a read of A000_00FC returns the written data.
- Assert `reset` during WAIT after a write acceptance → no `fin`, all outputs at reset values, and the written word is still readable afterwards.
